booth_mult_datapath: RTL and testbench
======================================

// Module: booth_mult_datapath
// PURPOSE
// - Radix-4 Booth multiplier datapath and sequencer. Sits directly downstream of the multdiv control unit.
// - Feeds that unit its 3-bit Booth window and consumes its aos/sm/nop/done decode.
// - Latches 32-bit signed operands, runs 16 add/sub+shift steps and presents a 32-bit product with overflow.
// - Result is held valid until the next start.
// PARAMETERS
// - WIDTH  32  operand/result width; must be even; steps = WIDTH/2
// PORTS
// - clk          in   1      rising-edge clock
// - clr          in   1      synchronous reset, active-low (0 = reset on next edge)
// - start        in   1      request; accepted only in IDLE or DONE
// - multiplicand in   WIDTH  signed operand M, sampled when start accepted
// - multiplier   in   WIDTH  signed operand Q, sampled when start accepted
// - booth_in     out  3      Booth window {Q[1],Q[0],q_m1} to control unit `in`
// - ctrl_clr     out  1      one-cycle pulse that restarts the control unit counter
// - aos          in   1      from control: 1 = subtract, 0 = add
// - sm           in   1      from control: 1 = use 2*M, 0 = use M
// - nop          in   1      from control: 1 = no add/sub this step
// - done         in   1      from control: current step is the last
// - busy         out  1      high in LOAD and RUN
// - result       out  WIDTH  low WIDTH bits of product
// - overflow     out  1      product not representable in WIDTH signed bits
// - result_valid out  1      high in DONE
// - seq_err      out  1      done arrived on a step other than WIDTH/2; sticky until next start
// BEHAVIOUR
// - Registers: acc[WIDTH+1:0] (two guard bits), Q[WIDTH-1:0], q_m1, step[4:0], FSM state.
// - Reset (clr=0 at edge): state=IDLE; acc, Q, q_m1, step cleared.
//   Outputs: result=0, overflow=0, result_valid=0, busy=0, seq_err=0, ctrl_clr=0.
// - FSM:
//   - IDLE -start-> LOAD.
//   - LOAD -> RUN, unconditional.
//   - RUN -done-> DONE.
//   - DONE -start-> LOAD.
//   - start in LOAD/RUN is ignored.
// - LOAD: latch M; Q=multiplier; acc=0; q_m1=0; step=0; ctrl_clr=1 for this cycle only.
// - RUN, each cycle:
//   - addend = sm ? sext(M)<<1 : sext(M), computed WIDTH+2 wide.
//   - sum = nop ? acc : (aos ? acc-addend : acc+addend).
//   - Arithmetic shift right by 2 of {sum,Q,q_m1}; step++.
//   - booth_in is combinational from registered Q[1:0], q_m1, so control sees the current window.
// - RUN, cycle with done=1: performs the final step, then enters DONE next edge.
//   - seq_err=1 if the post-increment step != WIDTH/2.
//   - Runaway guard: if step reaches 31 without done, enter DONE anyway with seq_err=1.
// - DONE: result = Q (low half of the 2*WIDTH product); held, with flags, until next LOAD.
//   - overflow=1 unless the upper bits acc[WIDTH-1:0] and result[WIDTH-1] are all equal.
// - Latency: start sampled at edge N -> LOAD in cycle N+1 -> 16 RUN cycles -> result_valid=1 from edge N+18.
// - On LOAD, result_valid drops the same edge; result and overflow keep their old values until DONE.
// - Reset mid-RUN aborts, clears all state; no partial result is exposed.
// - Arithmetic is two's complement throughout.
//   - -2^(WIDTH-1) as M with sm=1 must not lose its sign; hence the two guard bits.
// STRUCTURE
// - Shared package: FSM state encoding (IDLE/LOAD/RUN/DONE) and the STEPS=WIDTH/2 constant, reused by the control unit.
// - One natural sub-module: booth_addsub (WIDTH+2 add/sub with sm/nop select), combinational.
// - Register and FSM logic stay in this file.
// TESTING (bench instantiates this block plus the existing control unit)
// - 3 x 4 -> result=12, overflow=0, seq_err=0, result_valid exactly 18 cycles after start.
// - -7 x 6 -> result=0xFFFFFFD6 (-42), overflow=0.
// - 0x7FFFFFFF x 2 -> result=0xFFFFFFFE, overflow=1.
// - 0x80000000 x 0xFFFFFFFF -> result=0x80000000, overflow=1.
// - 0x80000000 x 1 -> result=0x80000000, overflow=0.
// - start pulsed at RUN step 5 -> ignored, result of original operands.
// - clr=0 at RUN step 8 -> next cycle IDLE, all outputs 0.
// - Back-to-back: start in DONE -> new run; result_valid low for 17 cycles.
// - Force done at step 10 (override control) -> DONE, seq_err=1.

Source files
------------

// File: rtl/booth_mult_datapath_pkg.sv
// Shared definitions for the radix-4 Booth multiplier datapath and its control unit.
// Holds the sequencer state encoding and the step-count constants.
package booth_mult_datapath_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2,
    StDone = 2'd3
  } booth_state_e;

  // Booth window {Q[1], Q[0], q_m1} handed to the control unit.
  typedef logic [2:0] booth_win_t;

  localparam int unsigned Width = 32;
  localparam int unsigned Steps = Width / 2;

  localparam int unsigned        StepW   = 5;
  localparam logic [StepW-1:0]   StepOne = StepW'(1);
  localparam logic [StepW-1:0]   StepMax = '1;

endpackage

// File: rtl/booth_addsub.sv
// Combinational add/sub stage of the Booth datapath: acc +/- M or 2*M, or pass-through.
// Works at WIDTH+2 bits so that -2^(WIDTH-1) doubled keeps its sign.
module booth_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH+1:0] acc_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic             aos_i,
  input  logic             sm_i,
  input  logic             nop_i,
  output logic [WIDTH+1:0] sum_o
);

  logic [WIDTH+1:0] addend;

  always_comb begin
    addend = sm_i ? {m_i[WIDTH-1], m_i, 1'b0} : {{2{m_i[WIDTH-1]}}, m_i};
    if (nop_i) begin
      sum_o = acc_i;
    end else if (aos_i) begin
      sum_o = acc_i - addend;
    end else begin
      sum_o = acc_i + addend;
    end
  end

endmodule

// File: rtl/booth_mult_datapath.sv
// Radix-4 Booth multiplier datapath and sequencer. Presents the Booth window to the
// control unit, applies its add/sub decode each step and holds the product until restart.
module booth_mult_datapath
  import booth_mult_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [2:0]       booth_in,
  output logic             ctrl_clr,
  input  logic             aos,
  input  logic             sm,
  input  logic             nop,
  input  logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  output logic             seq_err
);

  localparam logic [StepW-1:0] NumSteps = StepW'(WIDTH / 2);

  booth_state_e state_q, state_d;

  logic [WIDTH+1:0] acc_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [StepW-1:0] step_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             seq_err_q;

  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             qm1_sh;
  logic [StepW-1:0] step_inc;
  logic             ovf_sh;
  logic             ovf_cur;
  logic             accept;
  logic             runaway;

  booth_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .acc_i (acc_q),
    .m_i   (m_q),
    .aos_i (aos),
    .sm_i  (sm),
    .nop_i (nop),
    .sum_o (sum)
  );

  // Arithmetic shift right by two of {sum, Q, q_m1}.
  always_comb begin
    acc_sh   = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    q_sh     = {sum[1:0], q_q[WIDTH-1:2]};
    qm1_sh   = q_q[1];
    step_inc = step_q + StepOne;
    ovf_sh   = (acc_sh[WIDTH-1:0] != {WIDTH{q_sh[WIDTH-1]}});
    ovf_cur  = (acc_q[WIDTH-1:0] != {WIDTH{q_q[WIDTH-1]}});
    accept   = start && ((state_q == StIdle) || (state_q == StDone));
    runaway  = !done && (step_q == StepMax);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (done || runaway) state_d = StDone;
      StDone:  if (start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q == StLoad) || (state_q == StRun);
    ctrl_clr     = (state_q == StLoad);
    result_valid = (state_q == StDone);
    booth_in     = {q_q[1:0], qm1_q};
    result       = result_q;
    overflow     = overflow_q;
    seq_err      = seq_err_q;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      acc_q      <= '0;
      m_q        <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      step_q     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (accept) begin
      // Operands are captured on the accepting edge; the previous result stays visible.
      acc_q     <= '0;
      m_q       <= multiplicand;
      q_q       <= multiplier;
      qm1_q     <= 1'b0;
      step_q    <= '0;
      seq_err_q <= 1'b0;
    end else if (state_q == StRun) begin
      if (runaway) begin
        result_q   <= q_q;
        overflow_q <= ovf_cur;
        seq_err_q  <= 1'b1;
      end else begin
        acc_q  <= acc_sh;
        q_q    <= q_sh;
        qm1_q  <= qm1_sh;
        step_q <= step_inc;
        if (done) begin
          result_q   <= q_sh;
          overflow_q <= ovf_sh;
          seq_err_q  <= (step_inc != NumSteps);
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_datapath.sv
// Directed bench for booth_mult_datapath with a behavioural model of the multdiv control unit.
module tb_booth_mult_datapath;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [2:0]  booth_in;
  logic        ctrl_clr;
  logic        aos;
  logic        sm;
  logic        nop;
  logic        done;
  logic        busy;
  logic [31:0] result;
  logic        overflow;
  logic        result_valid;
  logic        seq_err;

  logic        ovr_en;
  logic        ovr_val;
  logic [4:0]  cnt;

  int checks;
  int errors;
  int elapsed;

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  booth_mult_datapath #(
    .WIDTH(32)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .booth_in     (booth_in),
    .ctrl_clr     (ctrl_clr),
    .aos          (aos),
    .sm           (sm),
    .nop          (nop),
    .done         (done),
    .busy         (busy),
    .result       (result),
    .overflow     (overflow),
    .result_valid (result_valid),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  // Control unit model: step counter restarted by ctrl_clr, radix-4 Booth decode.
  always_ff @(posedge clk) begin
    if (!clr || ctrl_clr) cnt <= '0;
    else                  cnt <= cnt + 5'd1;
  end

  always_comb begin
    aos = 1'b0;
    sm  = 1'b0;
    nop = 1'b0;
    case (booth_in)
      3'b000, 3'b111: nop = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         sm = 1'b1;
      3'b100:         begin aos = 1'b1; sm = 1'b1; end
      3'b101, 3'b110: aos = 1'b1;
      default:        nop = 1'b1;
    endcase
    done = ovr_en ? ovr_val : (cnt == 5'd15);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    elapsed++;
  endtask

  // Raise start just after an edge; returns just after the edge that sampled it.
  task automatic launch(input logic [31:0] m, input logic [31:0] q);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    elapsed      = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    while (!result_valid && elapsed < limit) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; clr = 1'b0; start = 1'b0; ovr_en = 1'b0; ovr_val = 1'b0;
    multiplicand = '0; multiplier = '0;
    checks = 0; errors = 0; elapsed = 0;

    vecs[0] = '{m: 32'd3,          q: 32'd4,          exp_res: 32'd12,         exp_ovf: 1'b0};
    vecs[1] = '{m: 32'hFFFFFFF9,   q: 32'd6,          exp_res: 32'hFFFFFFD6,   exp_ovf: 1'b0};
    vecs[2] = '{m: 32'h7FFFFFFF,   q: 32'd2,          exp_res: 32'hFFFFFFFE,   exp_ovf: 1'b1};
    vecs[3] = '{m: 32'h80000000,   q: 32'hFFFFFFFF,   exp_res: 32'h80000000,   exp_ovf: 1'b1};
    vecs[4] = '{m: 32'h80000000,   q: 32'd1,          exp_res: 32'h80000000,   exp_ovf: 1'b0};
    vecs[5] = '{m: 32'h80000000,   q: 32'h80000000,   exp_res: 32'h00000000,   exp_ovf: 1'b1};
    vecs[6] = '{m: 32'hFFFFFFFF,   q: 32'hFFFFFFFF,   exp_res: 32'h00000001,   exp_ovf: 1'b0};
    vecs[7] = '{m: 32'h00010000,   q: 32'h00010000,   exp_res: 32'h00000000,   exp_ovf: 1'b1};

    // Reset state
    tick(); tick();
    chk("rst_result", result, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_ctrl_clr", 32'(ctrl_clr), 32'd0);
    clr = 1'b1;
    tick();

    // LOAD cycle: one-cycle ctrl_clr, busy through LOAD and RUN
    launch(32'd3, 32'd4);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ctrl_clr", 32'(ctrl_clr), 32'd1);
    chk("load_valid", 32'(result_valid), 32'd0);
    tick();
    chk("run_ctrl_clr", 32'(ctrl_clr), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    wait_valid(60);
    chk("first_latency", 32'(elapsed), 32'd18);
    chk("first_result", result, 32'd12);
    chk("first_seq_err", 32'(seq_err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].m, vecs[i].q);
      wait_valid(60);
      chk($sformatf("vec%0d_latency", i), 32'(elapsed), 32'd18);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_seq_err", i), 32'(seq_err), 32'd0);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
    end

    // start at RUN step 5 is ignored: 5 * -3 = -15
    launch(32'd5, 32'hFFFFFFFD);
    while (elapsed < 7) tick();
    multiplicand = 32'd100;
    multiplier   = 32'd100;
    start        = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(60);
    chk("ign_start_latency", 32'(elapsed), 32'd18);
    chk("ign_start_result", result, 32'hFFFFFFF1);

    // clr at RUN step 8 aborts and zeroes everything
    launch(32'h7FFFFFFF, 32'd2);
    while (elapsed < 10) tick();
    clr = 1'b0;
    tick();
    chk("abort_result", result, 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_seq_err", 32'(seq_err), 32'd0);
    chk("abort_ctrl_clr", 32'(ctrl_clr), 32'd0);
    clr = 1'b1;
    tick(); tick();
    chk("abort_idle_valid", 32'(result_valid), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    // Back-to-back from DONE: old result held, valid low for 17 cycles
    launch(32'd2, 32'd3);
    wait_valid(60);
    chk("b2b_a_result", result, 32'd6);
    launch(32'hFFFFFFFC, 32'd5);
    chk("b2b_hold_result", result, 32'd6);
    begin
      int lows = 0;
      while (!result_valid && elapsed < 60) begin
        lows++;
        tick();
      end
      chk("b2b_low_cycles", 32'(lows), 32'd17);
    end
    chk("b2b_b_result", result, 32'hFFFFFFEC);

    // done forced at step 10 -> DONE with sticky seq_err
    launch(32'd7, 32'd9);
    while (elapsed < 12) tick();
    ovr_en  = 1'b1;
    ovr_val = 1'b1;
    tick();
    ovr_en  = 1'b0;
    ovr_val = 1'b0;
    chk("early_done_valid", 32'(result_valid), 32'd1);
    chk("early_done_seq_err", 32'(seq_err), 32'd1);
    chk("early_done_busy", 32'(busy), 32'd0);
    tick(); tick(); tick();
    chk("seq_err_sticky", 32'(seq_err), 32'd1);
    launch(32'd2, 32'd2);
    chk("seq_err_cleared", 32'(seq_err), 32'd0);
    wait_valid(60);
    chk("after_err_result", result, 32'd4);
    chk("after_err_seq_err", 32'(seq_err), 32'd0);

    // Control never signals done: runaway guard ends the run after 31 steps
    ovr_en  = 1'b1;
    ovr_val = 1'b0;
    launch(32'd3, 32'd4);
    wait_valid(80);
    chk("runaway_latency", 32'(elapsed), 32'd34);
    chk("runaway_seq_err", 32'(seq_err), 32'd1);
    ovr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
